fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS R2000 pipeline, directly upstream of the decode stage. Holds the program counter, drives a request/ready instruction-memory port, and owns the IF/ID pipeline register that feeds decode its `pc` and `inst_in` inputs. Honours decode's load-use hold, redirects on decode-resolved branches and jumps and on exceptions, and squashes wrong-path instructions by inserting NOPs.

## Interface
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `EXC_VECTOR`, 32'h0000_0080: redirect target on exception.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high: sampled on the rising edge of `clk`.
- `hold_pc`  in  1  load-use stall request from decode's hazard unit.
- `hold_if`  in  1  load-use stall request from decode's hazard unit.
- `br`  in  1  taken branch or jump resolved in decode.
- `pc_branch`  in  32  branch or jump target from decode.
- `exception`  in  1  illegal-opcode exception from decode.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  word address of the fetch.
- `imem_rdata`  in  32  instruction word returned by memory.
- `imem_ready`  in  1  rdata valid; completes the access.
- `inst_out`  out  32  IF/ID instruction, connected to decode `inst_in`.
- `pc_out`  out  32  IF/ID fetch address + 4, connected to decode `pc`.
- `valid_out`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Definitions:
  - `hold` = `hold_pc` | `hold_if`.
  - `redir` = (`br` | `exception`) & !`hold`. While `hold` is set, `br` and `exception` are ignored, because decode operands are stale during a stall; the held instruction is re-evaluated the next cycle.
  - `target` = `EXC_VECTOR` if `exception`, else `pc_branch`. Exception has priority over `br`.
- Registers: `pc_q` (current fetch address), `tgt_q`, `buf_q`, `state`, and the IF/ID register (`inst_out`, `pc_out`, `valid_out`).
- Squash means the IF/ID register loads `inst_out`=32'h0, `valid_out`=0. `pc_out` is unchanged.
- Bubble means the same load as squash.
- IDLE
  - `imem_req`=0.
  - Next edge goes to FETCH.
- FETCH
  - `imem_req`=1, `imem_addr`=`pc_q`.
  - `redir`:
    - If `imem_ready`: drop the data, `pc_q`<=`target`, squash, stay in FETCH.
    - If not `imem_ready`: `tgt_q`<=`target`, squash, go to DISCARD.
  - Else `imem_ready` & `hold`: `buf_q`<=`imem_rdata`, go to BUFFERED. IF/ID is held.
  - Else `imem_ready`: `inst_out`<=`imem_rdata`, `pc_out`<=`pc_q`+4, `valid_out`<=1, `pc_q`<=`pc_q`+4.
  - Else (`imem_ready`=0):
    - If `hold`: IF/ID is held.
    - Otherwise: bubble.
- DISCARD
  - `imem_req`=1, `imem_addr`=`pc_q` (old address).
  - IF/ID bubbles every cycle.
  - A new `redir` overwrites `tgt_q`.
  - On `imem_ready`: drop the data, `pc_q`<=`tgt_q`, or `target` if `redir` is set that same cycle. Go to FETCH.
- BUFFERED
  - `imem_req`=0. IF/ID is held while `hold`.
  - `redir`: drop `buf_q`, `pc_q`<=`target`, squash, go to FETCH.
  - Else `!hold`: `inst_out`<=`buf_q`, `pc_out`<=`pc_q`+4, `valid_out`<=1, `pc_q`<=`pc_q`+4, go to FETCH.
- Handshake rules:
  - Once `imem_req` is raised, `imem_addr` stays stable until the edge where `imem_ready`=1.
  - An access is never abandoned except by `rst`.
- Arithmetic: `pc_q`+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. The low two bits of a redirect target are forced to 0.

## Timing
- Reset (any edge with `rst`=1, including mid-access):
  - `state`=IDLE, `pc_q`=`RESET_PC`, `imem_req`=0.
  - `inst_out`=0, `pc_out`=0, `valid_out`=0.
  - `tgt_q`=0, `buf_q`=0.
  - `imem_req` is forced to 0 combinationally while `rst`=1.
- Latency:
  - First edge with `rst`=0 moves IDLE→FETCH.
  - With zero-wait memory, the following edge loads `RESET_PC`'s instruction into IF/ID.
- Throughput with `imem_ready` tied to 1: one instruction per cycle.
- Redirect: the target instruction appears in IF/ID two edges after the `redir` edge with zero wait states. Exactly one wrong-path slot is squashed.
- Wait states: each stall cycle produces one bubble unless `hold` is set.

## Structure
- Package `mips_pkg`:
  - `fetch_state_t` enum {IDLE, FETCH, DISCARD, BUFFERED}.
  - `NOP_INST` = 32'h0.
  - Default `EXC_VECTOR` constant.
- Sub-module `fetch_if_id_reg`: the IF/ID register with load, hold and squash controls and synchronous reset. The parent module holds the FSM and PC logic.

## Test plan
- Reset, then `imem_ready`=1 with memory returning `addr`^32'hA5A5_0000 → `inst_out` sequence for 0x0, 0x4, 0x8, one per cycle. `pc_out`=4, 8, 12. `imem_req`=0 in the first post-reset cycle.
- Two wait states at 0x4 → two cycles with `valid_out`=0, then the 0x4 word with `pc_out`=8. `imem_addr` stays 0x4 throughout.
- `br`=1, `pc_branch`=0x40 during a zero-wait FETCH → next IF/ID is a NOP with `valid_out`=0. Next `imem_addr`=0x40, and its word follows with `pc_out`=0x44.
- `exception` and `br` both set with `pc_branch`=0x40 while an access is pending → DISCARD. Old data dropped. The next request goes to 0x80.
- `hold_pc`=`hold_if`=1 for 3 cycles as data returns, with `br`=1 in the same cycles → IF/ID held and the data buffered with no redirect. After release, the buffered word loads and the PC advances by 4.
- `rst` asserted mid-access with `imem_ready`=0 → `imem_req` drops that cycle. All outputs read 0 on the next edge. Fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS R2000 fetch front end.
// Pulled in by the fetch stage and its IF/ID register.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    DISCARD  = 2'd2,
    BUFFERED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INST       = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

  // Redirect targets are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register with load/hold/squash controls and sync reset.
// A squash loads a NOP bubble but keeps pc_out unchanged.
module fetch_if_id_reg
  import mips_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_squash,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inst  <= NOP_INST;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_squash) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_inst  <= i_inst;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, request/ready imem port and IF/ID register.
//
//   state    | meaning
//   IDLE     | one cycle after reset, no request
//   FETCH    | request outstanding at pc_q
//   DISCARD  | finishing a wrong-path access, redirect target parked in tgt_q
//   BUFFERED | word returned during a hold, parked in buf_q
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold_pc,
  input  logic        i_hold_if,
  input  logic        i_br,
  input  logic [31:0] i_pc_branch,
  input  logic        i_exception,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [31:0] o_inst_out,
  output logic [31:0] o_pc_out,
  output logic        o_valid_out
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_tgt;
  logic [31:0]  r_buf;

  logic         w_hold;
  logic         w_redir;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_inc;

  logic         w_ifid_load;
  logic         w_ifid_squash;
  logic [31:0]  w_ifid_inst;

  // Decode operands are stale while holding, so redirects wait for release.
  assign w_hold   = i_hold_pc | i_hold_if;
  assign w_redir  = (i_br | i_exception) & ~w_hold;
  assign w_target = word_align(i_exception ? EXC_VECTOR : i_pc_branch);
  assign w_pc_inc = r_pc + 32'd4;

  assign o_imem_req  = ((r_state == FETCH) || (r_state == DISCARD)) & ~i_rst;
  assign o_imem_addr = r_pc;

  always_comb begin
    w_ifid_load   = 1'b0;
    w_ifid_squash = 1'b0;
    w_ifid_inst   = i_imem_rdata;
    case (r_state)
      FETCH: begin
        if (w_redir) begin
          w_ifid_squash = 1'b1;
        end else if (i_imem_ready && !w_hold) begin
          w_ifid_load = 1'b1;
        end else if (!i_imem_ready && !w_hold) begin
          w_ifid_squash = 1'b1;
        end
      end
      DISCARD: begin
        w_ifid_squash = 1'b1;
      end
      BUFFERED: begin
        w_ifid_inst = r_buf;
        if (w_redir) begin
          w_ifid_squash = 1'b1;
        end else if (!w_hold) begin
          w_ifid_load = 1'b1;
        end
      end
      default: begin
        w_ifid_load   = 1'b0;
        w_ifid_squash = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_tgt   <= 32'h0;
      r_buf   <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end
        FETCH: begin
          if (w_redir) begin
            if (i_imem_ready) begin
              r_pc <= w_target;
            end else begin
              r_tgt   <= w_target;
              r_state <= DISCARD;
            end
          end else if (i_imem_ready && w_hold) begin
            r_buf   <= i_imem_rdata;
            r_state <= BUFFERED;
          end else if (i_imem_ready) begin
            r_pc <= w_pc_inc;
          end
        end
        DISCARD: begin
          // The old access must complete before the target can be requested.
          if (w_redir) begin
            r_tgt <= w_target;
          end
          if (i_imem_ready) begin
            r_pc    <= w_redir ? w_target : r_tgt;
            r_state <= FETCH;
          end
        end
        BUFFERED: begin
          if (w_redir) begin
            r_pc    <= w_target;
            r_state <= FETCH;
          end else if (!w_hold) begin
            r_pc    <= w_pc_inc;
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  fetch_if_id_reg u_if_id (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_ifid_load),
    .i_squash (w_ifid_squash),
    .i_inst   (w_ifid_inst),
    .i_pc     (w_pc_inc),
    .o_inst   (o_inst_out),
    .o_pc     (o_pc_out),
    .o_valid  (o_valid_out)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr ^ 32'hA5A5_0000.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        hold_pc;
  logic        hold_if;
  logic        br;
  logic [31:0] pc_branch;
  logic        exception;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        valid_out;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hold_pc    (hold_pc),
    .i_hold_if    (hold_if),
    .i_br         (br),
    .i_pc_branch  (pc_branch),
    .i_exception  (exception),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_rdata (imem_rdata),
    .i_imem_ready (imem_ready),
    .o_inst_out   (inst_out),
    .o_pc_out     (pc_out),
    .o_valid_out  (valid_out)
  );

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                          input logic vld);
    chk({tag, ".inst"}, inst_out, inst);
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".valid"}, {31'b0, valid_out}, {31'b0, vld});
  endtask

  initial begin
    rst = 1'b1; hold_pc = 1'b0; hold_if = 1'b0; br = 1'b0;
    pc_branch = 32'h0; exception = 1'b0; imem_ready = 1'b1;
    step(); step();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);

    // Sequential zero-wait fetch
    rst = 1'b0;
    chk("idle_req", {31'b0, imem_req}, 32'h0);
    step();
    chk("fetch_req", {31'b0, imem_req}, 32'h1);
    chk("fetch_addr0", imem_addr, 32'h0);
    step();
    chk_ifid("seq0", 32'hA5A5_0000, 32'h4, 1'b1);
    chk("addr4", imem_addr, 32'h4);
    step();
    chk_ifid("seq4", 32'hA5A5_0004, 32'h8, 1'b1);
    step();
    chk_ifid("seq8", 32'hA5A5_0008, 32'hC, 1'b1);

    // Two wait states at 0xC
    imem_ready = 1'b0;
    chk("ws_addr_a", imem_addr, 32'hC);
    step();
    chk_ifid("ws1", 32'h0, 32'hC, 1'b0);
    chk("ws_addr_b", imem_addr, 32'hC);
    step();
    chk_ifid("ws2", 32'h0, 32'hC, 1'b0);
    chk("ws_addr_c", imem_addr, 32'hC);
    imem_ready = 1'b1;
    step();
    chk_ifid("wsC", 32'hA5A5_000C, 32'h10, 1'b1);

    // Zero-wait branch to 0x40
    br = 1'b1; pc_branch = 32'h40;
    step();
    br = 1'b0;
    chk_ifid("br_squash", 32'h0, 32'h10, 1'b0);
    chk("br_addr", imem_addr, 32'h40);
    step();
    chk_ifid("br_tgt", 32'hA5A5_0040, 32'h44, 1'b1);

    // Exception and branch together while the access is pending
    imem_ready = 1'b0; exception = 1'b1; br = 1'b1; pc_branch = 32'h40;
    step();
    exception = 1'b0; br = 1'b0;
    chk_ifid("exc_sq", 32'h0, 32'h44, 1'b0);
    chk("exc_req", {31'b0, imem_req}, 32'h1);
    chk("exc_old_addr", imem_addr, 32'h44);
    step();
    chk("exc_old_addr2", imem_addr, 32'h44);
    chk("exc_bub_valid", {31'b0, valid_out}, 32'h0);
    imem_ready = 1'b1;
    step();
    chk_ifid("exc_drop", 32'h0, 32'h44, 1'b0);
    chk("exc_vec_addr", imem_addr, 32'h80);
    step();
    chk_ifid("exc_tgt", 32'hA5A5_0080, 32'h84, 1'b1);

    // Hold for three cycles with a branch that must be ignored
    hold_pc = 1'b1; hold_if = 1'b1; br = 1'b1; pc_branch = 32'h200;
    step();
    chk_ifid("hold1", 32'hA5A5_0080, 32'h84, 1'b1);
    chk("hold_req", {31'b0, imem_req}, 32'h0);
    step();
    chk_ifid("hold2", 32'hA5A5_0080, 32'h84, 1'b1);
    step();
    chk_ifid("hold3", 32'hA5A5_0080, 32'h84, 1'b1);
    hold_pc = 1'b0; hold_if = 1'b0; br = 1'b0;
    step();
    chk_ifid("hold_rel", 32'hA5A5_0084, 32'h88, 1'b1);
    chk("hold_next_addr", imem_addr, 32'h88);

    // Misaligned branch target is word aligned
    br = 1'b1; pc_branch = 32'h103;
    step();
    br = 1'b0;
    chk("align_addr", imem_addr, 32'h100);
    step();
    chk_ifid("align_tgt", 32'hA5A5_0100, 32'h104, 1'b1);

    // Reset in the middle of a pending access
    imem_ready = 1'b0;
    step();
    chk("pre_rst_req", {31'b0, imem_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_req_comb", {31'b0, imem_req}, 32'h0);
    step();
    chk_ifid("mid_rst", 32'h0, 32'h0, 1'b0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    rst = 1'b0; imem_ready = 1'b1;
    step();
    chk("restart_addr", imem_addr, 32'h0);
    step();
    chk_ifid("restart", 32'hA5A5_0000, 32'h4, 1'b1);

    // PC wrap at the top of the address space
    br = 1'b1; pc_branch = 32'hFFFF_FFFC;
    step();
    br = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk_ifid("wrap", 32'h5A5A_FFFC, 32'h0, 1'b1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
